// File: rtl/scroll_controller.sv
// scroll_controller: per-frame scroll offset generator for the playfield.
// Offsets advance only on frame_tick while in RUN; an absolute position can
// be loaded over the cmd valid/ready port while IDLE.
// Optional feature: define SCROLL_ACCEL_EN to build the speed ramp
// (accel counter + saturating speed increment). Without it speed stays at
// START_SPEED for the whole of RUN.
module scroll_controller #(
    parameter int HWIDTH       = 12,
    parameter int VWIDTH       = 12,
    parameter int HWRAP        = 640,
    parameter int VWRAP        = 480,
    parameter int SWIDTH       = 4,
    parameter int START_SPEED  = 1,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     run,
    input  logic signed [SWIDTH-1:0] hstep,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic        [HWIDTH-1:0] cmd_hoffset,
    input  logic        [VWIDTH-1:0] cmd_voffset,
    output logic signed [HWIDTH-1:0] hoffset,
    output logic signed [VWIDTH-1:0] voffset,
    output logic        [SWIDTH-1:0] speed,
    output logic        [15:0]       frame_count
);

    typedef enum logic {IDLE, RUN} state_t;

    // Wrap limits carried one bit wider so sums can be range-checked
    // without losing the carry/borrow.
    localparam logic signed [HWIDTH:0] HWRAP_X = (HWIDTH+1)'(HWRAP);
    localparam logic signed [VWIDTH:0] VWRAP_X = (VWIDTH+1)'(VWRAP);
    localparam logic [SWIDTH-1:0]      START_S = SWIDTH'(START_SPEED);

    state_t state, state_nxt;

    logic signed [HWIDTH:0] h_sum, h_next, cmd_h_x, cmd_h_next;
    logic signed [VWIDTH:0] v_sum, v_next, cmd_v_x, cmd_v_next;
    logic                   advance;

`ifdef SCROLL_ACCEL_EN
    localparam int ACW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [SWIDTH-1:0] MAX_S = SWIDTH'(MAX_SPEED);

    logic [ACW-1:0]    accel_cnt;
    logic              accel_wrap;
    logic [SWIDTH-1:0] speed_up;

    // Ramp step: wrap detection on the pre-increment count, saturating speed.
    always_comb begin
        accel_wrap = (accel_cnt == ACW'(ACCEL_FRAMES - 1));
        speed_up   = (speed >= MAX_S) ? MAX_S : speed + 1'b1;
    end

    // Accel counter: cleared on RUN entry, counts RUN frames, clears on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            accel_cnt <= '0;
        else if (state == IDLE && run)
            accel_cnt <= '0;
        else if (advance)
            accel_cnt <= accel_wrap ? '0 : accel_cnt + 1'b1;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and command handshake; ready drops as soon as rst rises.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (run) state_nxt = RUN;
            end
            RUN: begin
                if (!run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Offset arithmetic: one conditional correction each way keeps results
    // in [0, WRAP) given in-range offsets and |hstep| < HWRAP.
    always_comb begin
        h_sum = {hoffset[HWIDTH-1], hoffset}
              + {{(HWIDTH+1-SWIDTH){hstep[SWIDTH-1]}}, hstep};
        if (h_sum < 0)             h_next = h_sum + HWRAP_X;
        else if (h_sum >= HWRAP_X) h_next = h_sum - HWRAP_X;
        else                       h_next = h_sum;

        v_sum = {voffset[VWIDTH-1], voffset}
              + {{(VWIDTH+1-SWIDTH){1'b0}}, speed};
        v_next = (v_sum >= VWRAP_X) ? v_sum - VWRAP_X : v_sum;

        cmd_h_x    = {1'b0, cmd_hoffset};
        cmd_h_next = (cmd_h_x >= HWRAP_X) ? cmd_h_x - HWRAP_X : cmd_h_x;
        cmd_v_x    = {1'b0, cmd_voffset};
        cmd_v_next = (cmd_v_x >= VWRAP_X) ? cmd_v_x - VWRAP_X : cmd_v_x;

        // Stop takes priority over a coincident tick.
        advance = (state == RUN) && run && frame_tick;
    end

    // Offsets, speed and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hoffset     <= '0;
            voffset     <= '0;
            speed       <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        hoffset <= cmd_h_next[HWIDTH-1:0];
                        voffset <= cmd_v_next[VWIDTH-1:0];
                    end
                    if (run) speed <= START_S;
                end
                RUN: begin
                    if (!run) begin
                        speed <= '0;
                    end else if (advance) begin
                        hoffset     <= h_next[HWIDTH-1:0];
                        voffset     <= v_next[VWIDTH-1:0];
                        frame_count <= frame_count + 16'd1;
`ifdef SCROLL_ACCEL_EN
                        if (accel_wrap) speed <= speed_up;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
